// File: rtl/dot_product_accumulator.sv
// rtl/dot_product_accumulator.sv - saturating dot-product accumulator with beat counting
module dot_product_accumulator #(
  parameter int BITWIDTH  = 8,
  parameter int ACC_WIDTH = 16,
  parameter int MAX_LEN   = 256,
  parameter int CNT_W     = $clog2(MAX_LEN) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BITWIDTH-1:0]  in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0]     out_count,
  output logic                 out_sat
);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 sat_q, sat_d;
  logic [ACC_WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 osat_q, osat_d;

  logic                 accept;
  logic [ACC_WIDTH:0]   sum_ext;
  logic                 overflow;
  logic [ACC_WIDTH-1:0] acc_next;
  logic [CNT_W-1:0]     cnt_next;
  logic                 sat_next;
  logic                 close_beat;

  // Handshake flags are straight decodes of the state register, so no input reaches an output.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = sum_q;
  assign out_count = count_q;
  assign out_sat   = osat_q;

  // Datapath: one extra carry bit detects overflow, and the sum clamps instead of wrapping.
  always_comb begin
    accept     = in_valid && (state_q == ACCUM);
    sum_ext    = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - BITWIDTH){1'b0}}, in_data};
    overflow   = sum_ext[ACC_WIDTH];
    acc_next   = overflow ? {ACC_WIDTH{1'b1}} : sum_ext[ACC_WIDTH-1:0];
    sat_next   = sat_q | overflow;
    cnt_next   = cnt_q + 1'b1;
    close_beat = in_last || (cnt_next == CNT_W'(MAX_LEN));
  end

  // Next-state logic: accumulate in ACCUM, latch result on a closing beat, clear on output handshake.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    sum_d   = sum_q;
    count_d = count_q;
    osat_d  = osat_q;
    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d = acc_next;
          cnt_d = cnt_next;
          sat_d = sat_next;
          if (close_beat) begin
            state_d = HOLD;
            sum_d   = acc_next;
            count_d = cnt_next;
            osat_d  = sat_next;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and result registers; reset drops any partial or pending vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      sum_q   <= '0;
      count_q <= '0;
      osat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      osat_q  <= osat_d;
    end
  end

endmodule
